// File: rtl/itcm_unit.sv
// Instruction TCM: byte-serial image loader feeding a 32-bit synchronous-read RAM,
// then answering fetch reads once the core has been released with start.
module itcm_unit #(
  parameter int          PC_SIZE    = 16,
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               itcm_ren,
  input  logic [PC_SIZE-1:0] pc,
  output logic [31:0]        instruct_in,
  input  logic               ld_valid,
  input  logic [7:0]         ld_byte,
  output logic               ld_ready,
  input  logic               ld_done,
  output logic               start,
  output logic               ld_overflow,
  output logic               addr_err
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {LOAD, FLUSH, RUN} state_t;
  state_t state, state_nxt;

  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [1:0]            byte_cnt;
  logic [31:0]           shreg;
  logic [31:0]           asm_word;
  logic [31:0]           wdata;
  logic                  ld_take, word_end, full, we;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           rd_data;
  logic                  rd_hit, rd_en, rd_oor, rd_ok;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [PC_SIZE-1:0]    pc_hi;

  always_ff @(posedge clk) begin
    if (rst_) state <= LOAD;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (ld_done) state_nxt = FLUSH;
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    ld_ready = (state == LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst_) start <= 1'b0;
    else      start <= (state_nxt == RUN);
  end

  // Incoming byte merged into the partial word at its little-endian lane.
  always_comb begin
    asm_word = shreg;
    asm_word[{byte_cnt, 3'b000} +: 8] = ld_byte;
  end

  assign full     = wr_ptr[DEPTH_LOG2];
  assign ld_take  = (state == LOAD) && ld_valid;
  assign word_end = (ld_take && byte_cnt == 2'd3) || (state == FLUSH && byte_cnt != 2'd0);
  assign wdata    = (state == FLUSH) ? shreg : asm_word;
  assign we       = word_end && !full;

  // Once full, wr_ptr parks at DEPTH so later reads of any index still see loaded data.
  always_ff @(posedge clk) begin
    if (rst_) begin
      wr_ptr      <= '0;
      byte_cnt    <= 2'd0;
      shreg       <= 32'd0;
      ld_overflow <= 1'b0;
    end else if (word_end) begin
      byte_cnt <= 2'd0;
      shreg    <= 32'd0;
      if (full) ld_overflow <= 1'b1;
      else      wr_ptr      <= wr_ptr + 1'b1;
    end else if (ld_take) begin
      byte_cnt <= byte_cnt + 2'd1;
      shreg    <= asm_word;
    end
  end

  assign rd_en  = (state == RUN) && itcm_ren;
  assign rd_idx = pc[DEPTH_LOG2+1:2];
  assign pc_hi  = pc >> (DEPTH_LOG2 + 2);
  assign rd_oor = |pc_hi;
  assign rd_ok  = !rd_oor && ({1'b0, rd_idx} < wr_ptr);

  always_ff @(posedge clk) begin
    if (we)    mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
    if (rd_en) rd_data <= mem[rd_idx];
  end

  // rd_hit selects RAM data vs NOP; both hold while itcm_ren is low.
  always_ff @(posedge clk) begin
    if (rst_) begin
      rd_hit   <= 1'b0;
      addr_err <= 1'b0;
    end else if (rd_en) begin
      rd_hit <= rd_ok;
      if (pc[1:0] != 2'd0 || rd_oor) addr_err <= 1'b1;
    end
  end

  assign instruct_in = rd_hit ? rd_data : NOP_WORD;
endmodule

// File: tb/tb_itcm_unit.sv
// Bench for itcm_unit: a 1024-word and a 4-word instance share all stimulus and
// are each compared against a byte-image reference model.
module tb_itcm_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 0;
  logic        rst_ = 1;
  logic        itcm_ren = 0;
  logic [15:0] pc = '0;
  logic        ld_valid = 0;
  logic [7:0]  ld_byte = '0;
  logic        ld_done = 0;

  logic [31:0] ib, is;
  logic rdy_b, rdy_s, st_b, st_s, ov_b, ov_s, ae_b, ae_s;

  itcm_unit #(.PC_SIZE(16), .DEPTH_LOG2(10)) u_big (
    .clk(clk), .rst_(rst_), .itcm_ren(itcm_ren), .pc(pc), .instruct_in(ib),
    .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(rdy_b), .ld_done(ld_done),
    .start(st_b), .ld_overflow(ov_b), .addr_err(ae_b));

  itcm_unit #(.PC_SIZE(16), .DEPTH_LOG2(2)) u_small (
    .clk(clk), .rst_(rst_), .itcm_ren(itcm_ren), .pc(pc), .instruct_in(is),
    .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(rdy_s), .ld_done(ld_done),
    .start(st_s), .ld_overflow(ov_s), .addr_err(ae_s));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  img[$];
  logic [7:0]  stim[64];
  logic [31:0] exp_ib, exp_is;
  logic        err_b, err_s;

  typedef struct {
    bit          ren;
    logic [15:0] pc;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[8];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: the image is a flat byte list; word i is bytes 4i..4i+3, zero padded.
  function automatic logic [31:0] model_word(input int idx);
    logic [31:0] w = '0;
    for (int b = 0; b < 4; b++)
      if (4 * idx + b < img.size()) w[8*b +: 8] = img[4*idx + b];
    return w;
  endfunction

  function automatic int nwords();
    return (img.size() + 3) / 4;
  endfunction

  function automatic logic [31:0] model_read(input int pcv, input int dl);
    int depth = 1 << dl;
    int loaded = (nwords() < depth) ? nwords() : depth;
    int idx = pcv / 4;
    if (idx >= depth || idx >= loaded) return NOP;
    return model_word(idx);
  endfunction

  function automatic bit model_err(input int pcv, input int dl);
    return (pcv % 4 != 0) || (pcv / 4 >= (1 << dl));
  endfunction

  task automatic do_reset();
    rst_ = 1; ld_valid = 0; ld_done = 0; itcm_ren = 0;
    tick();
    chk("rst_instr_big", ib, NOP);   chk("rst_instr_small", is, NOP);
    chk("rst_ready_big", rdy_b, 1);  chk("rst_ready_small", rdy_s, 1);
    chk("rst_start_big", st_b, 0);   chk("rst_start_small", st_s, 0);
    chk("rst_ovf_big", ov_b, 0);     chk("rst_ovf_small", ov_s, 0);
    chk("rst_aerr_big", ae_b, 0);    chk("rst_aerr_small", ae_s, 0);
    tick();
    rst_ = 0;
    img.delete();
    exp_ib = NOP; exp_is = NOP; err_b = 0; err_s = 0;
  endtask

  task automatic send_bytes(input int n, input bit done_last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        tick();
        chk("gap_ready", rdy_b, 1);
      end
      ld_valid = 1; ld_byte = stim[i]; ld_done = done_last && (i == n - 1);
      tick();
      ld_valid = 0; ld_done = 0;
      img.push_back(stim[i]);
      if (!(done_last && i == n - 1)) begin
        chk("load_ready_big", rdy_b, 1); chk("load_ready_small", rdy_s, 1);
        chk("load_start_big", st_b, 0);  chk("load_start_small", st_s, 0);
      end
    end
  endtask

  task automatic load_img(input int n, input bit done_last, input bit gaps);
    send_bytes(n, done_last, gaps);
    if (!done_last || n == 0) begin
      ld_done = 1; tick(); ld_done = 0;
    end
    chk("flush_ready_big", rdy_b, 0); chk("flush_ready_small", rdy_s, 0);
    chk("flush_start_big", st_b, 0);  chk("flush_start_small", st_s, 0);
    tick();
    chk("run_start_big", st_b, 1);    chk("run_start_small", st_s, 1);
    chk("ovf_big", ov_b, nwords() > 1024);
    chk("ovf_small", ov_s, nwords() > 4);
  endtask

  task automatic fetch(input bit ren, input logic [15:0] p);
    itcm_ren = ren; pc = p;
    tick();
    itcm_ren = 0;
    if (ren) begin
      exp_ib = model_read(p, 10); exp_is = model_read(p, 2);
      err_b |= model_err(p, 10);  err_s |= model_err(p, 2);
    end
    chk("instr_big", ib, exp_ib); chk("instr_small", is, exp_is);
    chk("aerr_big", ae_b, err_b); chk("aerr_small", ae_s, err_s);
  endtask

  logic [15:0] rpc;

  initial begin
    // Two words, ld_done on its own cycle, then table-driven fetches.
    do_reset();
    stim[0] = 8'h13; stim[1] = 8'h05; stim[2] = 8'h00; stim[3] = 8'h00;
    stim[4] = 8'h93; stim[5] = 8'h05; stim[6] = 8'h15; stim[7] = 8'h00;
    load_img(8, 0, 0);
    tbl[0] = '{1, 16'h0000, 32'h0000_0513};
    tbl[1] = '{1, 16'h0004, 32'h0015_0593};
    tbl[2] = '{0, 16'h0008, 32'h0015_0593};
    tbl[3] = '{1, 16'h0008, NOP};
    tbl[4] = '{1, 16'h0002, 32'h0000_0513};
    tbl[5] = '{1, 16'h0010, NOP};
    tbl[6] = '{0, 16'h0000, NOP};
    tbl[7] = '{1, 16'h0004, 32'h0015_0593};
    for (int i = 0; i < 8; i++) begin
      fetch(tbl[i].ren, tbl[i].pc);
      chk("tbl_big", ib, tbl[i].exp);
      chk("tbl_small", is, tbl[i].exp);
    end
    chk("sticky_aerr_big", ae_b, 1);
    for (int i = 0; i < 3; i++) fetch(0, 16'h0000);
    chk("hold_instr", ib, 32'h0015_0593);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_byte = 8'hFF; ld_done = (i == 3);
      tick();
      chk("run_ready_big", rdy_b, 0); chk("run_ready_small", rdy_s, 0);
    end
    ld_valid = 0; ld_done = 0;
    fetch(1, 16'h0000);
    chk("run_ld_ignored", ib, 32'h0000_0513);
    fetch(1, 16'h0008);

    // Reset mid-word; fetches during LOAD stay NOP and raise no error.
    do_reset();
    itcm_ren = 1; pc = 16'h0002;
    stim[0] = 8'hEE; stim[1] = 8'hEE;
    send_bytes(2, 0, 0);
    chk("load_fetch_nop", ib, NOP);
    chk("load_fetch_noerr", ae_b, 0);
    itcm_ren = 0;
    do_reset();
    stim[0] = 8'h37; stim[1] = 8'h12; stim[2] = 8'h00; stim[3] = 8'h00;
    load_img(4, 0, 0);
    fetch(1, 16'h0000);
    chk("reset_word0", ib, 32'h0000_1237);
    fetch(1, 16'h0004);

    // Partial final word with ld_done alongside the last byte.
    do_reset();
    stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC;
    stim[3] = 8'hDD; stim[4] = 8'h11; stim[5] = 8'h22;
    load_img(6, 1, 0);
    fetch(1, 16'h0004);
    chk("partial_word1", ib, 32'h0000_2211);
    fetch(1, 16'h0000);
    chk("partial_word0", ib, 32'hDDCC_BBAA);
    fetch(1, 16'h0008);

    // Five words: overflows only the 4-word instance.
    do_reset();
    for (int i = 0; i < 20; i++) stim[i] = 8'($urandom);
    load_img(20, 0, 0);
    chk("ovf5_small", ov_s, 1);
    for (int a = 0; a <= 16; a += 4) fetch(1, 16'(a));
    chk("ovf5_nop", is, NOP);
    chk("ovf5_aerr_small", ae_s, 1);
    chk("ovf5_aerr_big", ae_b, 0);

    // Randomized images and fetch streams against the model.
    for (int it = 0; it < 12; it++) begin
      int n;
      do_reset();
      n = $urandom_range(0, 30);
      for (int i = 0; i < n; i++) stim[i] = 8'($urandom);
      load_img(n, 1'($urandom_range(0, 1)), 1);
      for (int k = 0; k < 24; k++) begin
        case ($urandom_range(0, 3))
          0: rpc = 16'(4 * $urandom_range(0, nwords() + 2));
          1: rpc = 16'(4 * $urandom_range(0, 9) + $urandom_range(1, 3));
          2: rpc = 16'($urandom_range(16'h0100, 16'hFFFF));
          default: rpc = 16'(4 * $urandom_range(0, 7));
        endcase
        fetch(1'($urandom_range(0, 3) != 0), rpc);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
